piso_serializer: RTL and testbench



---
 rtl/piso_serializer.sv | 102 ++++++++++
 tb/tb_piso_serializer.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/piso_serializer.sv
// rtl/piso_serializer.sv - parallel-in/serial-out transmitter, MSB first, valid/ready word input.
// Optional macro PARITY_EN appends one even-parity bit after each frame.
module piso_serializer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             sout_first,
  output logic             busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
`ifdef PARITY_EN
  localparam logic [1:0] PARITY = 2'd2;
`endif

  logic [1:0]       state;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    cnt;
  logic             last_bit;
  logic             xfer;

  assign last_bit = (state == SHIFT) && (cnt == CW'(WIDTH - 1));

`ifdef PARITY_EN
  logic par;

  // The next word is taken during the parity cycle, so frames stay gapless.
  assign din_ready = rst_n && ((state == IDLE) || (state == PARITY));
  assign sout      = (state == SHIFT)  ? shreg[WIDTH-1] :
                     (state == PARITY) ? par : 1'b0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      shreg <= '0;
      cnt   <= '0;
      par   <= 1'b0;
    end else if (xfer) begin
      state <= SHIFT;
      shreg <= din;
      cnt   <= '0;
      par   <= 1'b0;
    end else begin
      case (state)
        SHIFT: begin
          par <= par ^ shreg[WIDTH-1];
          if (last_bit) begin
            state <= PARITY;
          end else begin
            shreg <= {shreg[WIDTH-2:0], 1'b0};
            cnt   <= cnt + 1'b1;
          end
        end
        PARITY:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
`else
  // The next word may load on the final data bit, giving back-to-back frames.
  assign din_ready = rst_n && ((state == IDLE) || last_bit);
  assign sout      = (state == SHIFT) ? shreg[WIDTH-1] : 1'b0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      shreg <= '0;
      cnt   <= '0;
    end else if (xfer) begin
      state <= SHIFT;
      shreg <= din;
      cnt   <= '0;
    end else begin
      case (state)
        SHIFT: begin
          if (last_bit) begin
            state <= IDLE;
          end else begin
            shreg <= {shreg[WIDTH-2:0], 1'b0};
            cnt   <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
`endif

  assign xfer       = din_valid && din_ready;
  assign sout_valid = (state != IDLE);
  assign busy       = (state != IDLE);
  assign sout_first = (state == SHIFT) && (cnt == '0);

endmodule

// File: tb/tb_piso_serializer.sv
// tb/tb_piso_serializer.sv - directed self-checking bench for piso_serializer (WIDTH=8).
module tb_piso_serializer;

  logic       clk;
  logic       rst_n;
  logic [7:0] din;
  logic       din_valid;
  logic       din_ready;
  logic       sout;
  logic       sout_valid;
  logic       sout_first;
  logic       busy;

  int checks = 0;
  int errors = 0;

  piso_serializer #(.WIDTH(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din        (din),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .sout       (sout),
    .sout_valid (sout_valid),
    .sout_first (sout_first),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".sout"}, 32'(sout), 0);
    check({tag, ".sout_valid"}, 32'(sout_valid), 0);
    check({tag, ".sout_first"}, 32'(sout_first), 0);
    check({tag, ".busy"}, 32'(busy), 0);
    check({tag, ".din_ready"}, 32'(din_ready), 1);
  endtask

  // Caller has w on din with din_valid=1 and din_ready=1; w loads at the next edge.
  // From the first bit onward din/din_valid are driven with nxt/nxt_valid.
  task automatic tx_word(input string tag, input logic [7:0] w, input logic [7:0] nxt,
                         input logic nxt_valid);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      din       = nxt;
      din_valid = nxt_valid;
      check($sformatf("%s.bit%0d", tag, i), 32'(sout), 32'(w[7-i]));
      check($sformatf("%s.valid%0d", tag, i), 32'(sout_valid), 1);
      check($sformatf("%s.first%0d", tag, i), 32'(sout_first), 32'(i == 0));
      check($sformatf("%s.busy%0d", tag, i), 32'(busy), 1);
`ifdef PARITY_EN
      check($sformatf("%s.ready%0d", tag, i), 32'(din_ready), 0);
`else
      check($sformatf("%s.ready%0d", tag, i), 32'(din_ready), 32'(i == 7));
`endif
    end
`ifdef PARITY_EN
    @(negedge clk);
    check({tag, ".par"}, 32'(sout), 32'(^w));
    check({tag, ".par_valid"}, 32'(sout_valid), 1);
    check({tag, ".par_first"}, 32'(sout_first), 0);
    check({tag, ".par_busy"}, 32'(busy), 1);
    check({tag, ".par_ready"}, 32'(din_ready), 1);
`endif
  endtask

  initial begin
    rst_n     = 1'b0;
    din       = 8'hA5;
    din_valid = 1'b1;

    #2;
    check("rst.din_ready", 32'(din_ready), 0);
    check("rst.sout", 32'(sout), 0);
    check("rst.sout_valid", 32'(sout_valid), 0);
    check("rst.sout_first", 32'(sout_first), 0);
    check("rst.busy", 32'(busy), 0);
    repeat (2) @(negedge clk);
    check("rst_hold.din_ready", 32'(din_ready), 0);
    check("rst_hold.sout_valid", 32'(sout_valid), 0);

    din_valid = 1'b0;
    rst_n     = 1'b1;
    @(negedge clk);
    check_idle("post_rst");

    // Single word A5 -> 1,0,1,0,0,1,0,1
    din       = 8'hA5;
    din_valid = 1'b1;
    tx_word("a5", 8'hA5, 8'h00, 1'b0);
    @(negedge clk);
    check_idle("a5_end");

    // Back-to-back FF then 00 with din_valid held high.
    din       = 8'hFF;
    din_valid = 1'b1;
    tx_word("ff", 8'hFF, 8'h00, 1'b1);
    tx_word("00", 8'h00, 8'h00, 1'b0);
    @(negedge clk);
    check_idle("b2b_end");

    // 3C loaded, then FF presented while not ready: must wait for the last bit.
    din       = 8'h3C;
    din_valid = 1'b1;
    tx_word("3c", 8'h3C, 8'hFF, 1'b1);
    tx_word("3c_ff", 8'hFF, 8'h00, 1'b0);
    @(negedge clk);
    check_idle("ign_end");

`ifdef PARITY_EN
    din       = 8'h07;
    din_valid = 1'b1;
    tx_word("p07", 8'h07, 8'h00, 1'b0);
    check("p07.hand_par", 32'(sout), 1);
    @(negedge clk);
    check_idle("p07_end");
    din       = 8'hA5;
    din_valid = 1'b1;
    tx_word("pa5", 8'hA5, 8'h00, 1'b0);
    check("pa5.hand_par", 32'(sout), 0);
    @(negedge clk);
    check_idle("pa5_end");
`endif

    // Reset mid-frame on C3 after three bits.
    din       = 8'hC3;
    din_valid = 1'b1;
    @(negedge clk);
    din_valid = 1'b0;
    check("mid.bit0", 32'(sout), 1);
    check("mid.first0", 32'(sout_first), 1);
    @(negedge clk);
    check("mid.bit1", 32'(sout), 1);
    @(negedge clk);
    check("mid.bit2", 32'(sout), 0);
    check("mid.valid2", 32'(sout_valid), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst.sout_valid", 32'(sout_valid), 0);
    check("mid_rst.sout", 32'(sout), 0);
    check("mid_rst.busy", 32'(busy), 0);
    check("mid_rst.din_ready", 32'(din_ready), 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_idle($sformatf("mid_after%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
